uart_rx_framed: RTL and testbench

Parametrised UART receiver: the next generation of our fixed 8N1 receiver. It samples an asynchronous serial line at mid-bit, assembles LSB-first words of configurable width, and checks optional parity and one or two stop bits. Each word, with its error flags, is pushed into a small show-ahead FIFO that downstream logic drains through a valid/ready handshake. It sits between the board RX pin and any command or data consumer in the design.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_fifo.sv | 91 +++++++++
 rtl/uart_rx_framed.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the framed UART receiver.
//   rx_state_e  : receiver FSM state encoding
//   PAR_*       : parity mode constants (none / odd / even)
//   parity_bit  : expected parity bit for a data word under a given mode
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // data_xor is the XOR-reduction of the data bits; the result is the
    // parity bit a correct transmitter would send in that mode.
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        logic bit_s;
        case (mode)
            PAR_ODD:  bit_s = ~data_xor;
            PAR_EVEN: bit_s = data_xor;
            default:  bit_s = 1'b0;
        endcase
        return bit_s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead word FIFO with valid/ready pop.
//   clk_i, rst_ni   : clock, async active-low reset
//   push_i          : write push_data_i this cycle
//   pop_ready_i     : consumer takes the head when valid_o is high
//   head_o          : head word (zero while empty)
//   valid_o         : FIFO not empty
//   overrun_o       : one-cycle pulse when a push is dropped because full
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             overrun_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             overrun_q, overrun_d;
    logic             empty_s, full_s, pop_s, wr_en_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_s   = !empty_s && pop_ready_i;
    // A simultaneous pop frees the head slot, so a push while full still lands.
    assign wr_en_s = push_i && (!full_s || pop_s);

    // Pointer advance and drop detection.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = push_i && full_s && !pop_s;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and overrun-pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= {(AW+1){1'b0}};
            rd_ptr_q  <= {(AW+1){1'b0}};
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Show-ahead head; forced to zero while empty so stale slots never leak out.
    always_comb begin
        if (empty_s) begin
            head_o = {WIDTH{1'b0}};
        end else begin
            head_o = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign valid_o   = !empty_s;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver with word FIFO.
//   clk, rst_n   : clock, async active-low reset
//   rx           : raw serial line (idle high)
//   rx_data      : FIFO head word; rx_valid: FIFO not empty; rx_ready: pop
//   frame_err    : head word had a low stop bit
//   parity_err   : head word failed parity (0 when parity is disabled)
//   overrun      : one-cycle pulse when a finished word is dropped (FIFO full)
//   busy         : a frame is being received
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam int             FW        = DATA_BITS + 2;
    localparam logic [TW-1:0]  HALF_M1   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1   = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [1:0]     PAR_MODE  = 2'(PARITY);

    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 armed_q, armed_d;
    logic                 busy_q;
    logic                 sample_s, stop_err_s, push_s;
    logic [FW-1:0]        head_s;

    // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // The start bit is sampled half a bit in; every later sample is one full bit apart.
    assign sample_s = (state_q == ST_START) ? (timer_q == HALF_M1) : (timer_q == FULL_M1);

    // Next-state, bit timer, shift register and error accumulation.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        armed_d    = armed_q;
        push_s     = 1'b0;
        stop_err_s = frm_err_q | ~rx_sync_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = {TW{1'b0}};
                // Seeing the line high re-arms after a framing error (break).
                if (rx_sync_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    timer_d   = {TW{1'b0}};
                    bit_cnt_d = 4'd0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                    state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    timer_d   = {TW{1'b0}};
                    shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    timer_d   = {TW{1'b0}};
                    par_err_d = (rx_sync_q != parity_bit(PAR_MODE, ^shift_q));
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_s) begin
                    timer_d   = {TW{1'b0}};
                    frm_err_d = stop_err_s;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_STOP) begin
                        push_s  = 1'b1;
                        state_d = ST_IDLE;
                        // A held-low break must produce only one word.
                        if (stop_err_s) begin
                            armed_d = 1'b0;
                        end else begin
                            armed_d = armed_q;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= {TW{1'b0}};
            bit_cnt_q <= 4'd0;
            shift_q   <= {DATA_BITS{1'b0}};
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            armed_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            armed_q   <= armed_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push_s),
        .push_data_i ({stop_err_s, par_err_q, shift_q}),
        .pop_ready_i (rx_ready),
        .head_o      (head_s),
        .valid_o     (rx_valid),
        .overrun_o   (overrun)
    );

    assign rx_data    = head_s[DATA_BITS-1:0];
    assign parity_err = head_s[DATA_BITS];
    assign frame_err  = head_s[DATA_BITS+1];
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: instance A is 8N1, instance B is 7 data bits,
// even parity, 1 stop. Both use 16 clocks per bit and a 4-word FIFO.
module tb_uart_rx_framed;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, rx_ready_a, rx_ready_b;
    logic [7:0] rx_data_a;
    logic [6:0] rx_data_b;
    logic       rx_valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
    logic       rx_valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc_a = 0, start_cyc_b = 0;
    int   rise_cyc_a = -1, rise_cyc_b = -1, ovr_cyc_a = -1;
    int   ovr_hi_a = 0, exp_ovr_a = 0;

    always #5 clk = ~clk;

    uart_rx_framed #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
        .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_framed #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
        .overrun(overrun_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cycles from driving the start bit to rx_valid seen: middle of the last
    // stop bit, plus synchroniser delay and the push register.
    function automatic int frame_lat(input int nbits, input int npar);
        return (1 + nbits + npar) * CPB + CPB / 2 + 3;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor / scoreboard for instance A.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid_a && !prev_v) rise_cyc_a = cyc;
            prev_v = rx_valid_a;
            if (overrun_a) begin
                ovr_hi_a++;
                ovr_cyc_a = cyc;
            end
            if (rx_valid_a && rx_ready_a) begin
                if (exp_a.size() == 0) begin
                    chk("a_spurious_word", {31'd0, rx_valid_a}, 32'd0);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_data", {24'd0, rx_data_a}, {23'd0, e.data});
                    chk("a_frame_err", {31'd0, frame_err_a}, {31'd0, e.fe});
                    chk("a_parity_err", {31'd0, parity_err_a}, {31'd0, e.pe});
                end
            end
        end
    end

    // Output monitor / scoreboard for instance B.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid_b && !prev_v) rise_cyc_b = cyc;
            prev_v = rx_valid_b;
            if (overrun_b) chk("b_overrun", {31'd0, overrun_b}, 32'd0);
            if (rx_valid_b && rx_ready_b) begin
                if (exp_b.size() == 0) begin
                    chk("b_spurious_word", {31'd0, rx_valid_b}, 32'd0);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_data", {25'd0, rx_data_b}, {23'd0, e.data});
                    chk("b_frame_err", {31'd0, frame_err_b}, {31'd0, e.fe});
                    chk("b_parity_err", {31'd0, parity_err_b}, {31'd0, e.pe});
                end
            end
        end
    end

    // Drive one line level for a number of cycles; always leaves time at posedge+1.
    task automatic drive_line(input bit sel_b, input logic v, input int cycles);
        if (sel_b) rx_b = v;
        else       rx_a = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Send one frame and record the expected word. B uses even parity.
    task automatic send_frame(input bit sel_b, input logic [8:0] data,
                              input logic stop_val, input logic par_flip);
        exp_t       e;
        logic [8:0] d;
        int         nbits;
        nbits  = sel_b ? 7 : 8;
        d      = data & (sel_b ? 9'h07F : 9'h0FF);
        e.data = d;
        e.fe   = ~stop_val;
        e.pe   = sel_b ? par_flip : 1'b0;
        if (sel_b) begin
            exp_b.push_back(e);
            start_cyc_b = cyc;
        end else begin
            if (!rx_ready_a && exp_a.size() == DEPTH) exp_ovr_a++;
            else exp_a.push_back(e);
            start_cyc_a = cyc;
        end
        drive_line(sel_b, 1'b0, CPB);
        for (int i = 0; i < nbits; i++) drive_line(sel_b, d[i], CPB);
        if (sel_b) drive_line(sel_b, (^d[6:0]) ^ par_flip, CPB);
        drive_line(sel_b, stop_val, CPB);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(tag, exp_a.size() + exp_b.size(), 32'd0);
    endtask

    // Reset both instances; everything pending in the FIFOs is discarded.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        exp_a.delete();
        exp_b.delete();
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_valid_a"}, {31'd0, rx_valid_a}, 32'd0);
        chk({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_overrun_a"}, {31'd0, overrun_a}, 32'd0);
        chk({tag, "_data_a"}, {24'd0, rx_data_a}, 32'd0);
        chk({tag, "_flags_a"}, {30'd0, frame_err_a, parity_err_a}, 32'd0);
        chk({tag, "_valid_b"}, {31'd0, rx_valid_b}, 32'd0);
        chk({tag, "_busy_b"}, {31'd0, busy_b}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_a       = 1'b1;
        rx_b       = 1'b1;
        rx_ready_a = 1'b1;
        rx_ready_b = 1'b1;
        #1;
        do_reset("rst");
        drive_line(0, 1'b1, 2 * CPB);

        // 1: two clean 8N1 frames, popped as they arrive.
        send_frame(0, 9'h055, 1'b1, 1'b0);
        chk("t1_lat_55", rise_cyc_a - start_cyc_a, frame_lat(8, 0));
        send_frame(0, 9'h0A3, 1'b1, 1'b0);
        chk("t1_lat_a3", rise_cyc_a - start_cyc_a, frame_lat(8, 0));
        wait_drain("t1_drain");

        // 2: 7E1, bad parity then good parity.
        send_frame(1, 9'h041, 1'b1, 1'b1);
        chk("t2_lat", rise_cyc_b - start_cyc_b, frame_lat(7, 1));
        send_frame(1, 9'h023, 1'b1, 1'b0);
        wait_drain("t2_drain");

        // 3: 4-cycle glitch; busy pulses, no word.
        rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_busy_rise", {31'd0, busy_a}, 32'd1);
        @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t3_busy_fall", {31'd0, busy_a}, 32'd0);
        drive_line(0, 1'b1, 2 * CPB);
        chk("t3_no_word", {31'd0, rx_valid_a}, 32'd0);

        // 4: framing error followed by a long break, then a clean frame.
        send_frame(0, 9'h07E, 1'b0, 1'b0);
        drive_line(0, 1'b0, 40 * CPB);
        wait_drain("t4_break_drain");
        drive_line(0, 1'b1, 2 * CPB);
        send_frame(0, 9'h012, 1'b1, 1'b0);
        wait_drain("t4_drain");

        // 5: five frames into a 4-deep FIFO with no consumer.
        rx_ready_a = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b1, 1'b0);
        chk("t5_overrun_at_stop", ovr_cyc_a - start_cyc_a, frame_lat(8, 0));
        chk("t5_head_valid", {31'd0, rx_valid_a}, 32'd1);
        chk("t5_head_data", {24'd0, rx_data_a}, 32'h01);
        rx_ready_a = 1'b1;
        wait_drain("t5_drain");
        chk("t5_overrun_cycles", ovr_hi_a, exp_ovr_a);

        // 6: stored word plus a frame cut off by reset; then a clean frame.
        rx_ready_a = 1'b0;
        send_frame(0, 9'h099, 1'b1, 1'b0);
        chk("t6_pre_valid", {31'd0, rx_valid_a}, 32'd1);
        chk("t6_pre_data", {24'd0, rx_data_a}, 32'h99);
        drive_line(0, 1'b0, CPB);
        drive_line(0, 1'b1, CPB);
        drive_line(0, 1'b0, CPB + CPB / 2);
        chk("t6_pre_busy", {31'd0, busy_a}, 32'd1);
        rx_a = 1'b1;
        do_reset("t6_rst");
        rx_ready_a = 1'b1;
        drive_line(0, 1'b1, 2 * CPB);
        send_frame(0, 9'h03C, 1'b1, 1'b0);
        wait_drain("t6_drain");
        drive_line(0, 1'b1, 2 * CPB);
        chk("t6_single_word", {31'd0, rx_valid_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
